// File: rtl/qspi_target.sv
// QSPI responder (PSRAM-style): oversamples SCK/CE#/SIO, serves 0xEB quad read and 0x38 quad write from internal RAM.
// Define QSPI_TGT_RSTCMD_EN to decode the 0x66 -> 0x99 reset-command sequence onto rst_cmd.
module qspi_target #(
  parameter int MEM_AW   = 10,
  parameter int WAIT_CYC = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ce_n,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic              sio_oe,
  output logic              busy,
  output logic              cmd_err,
  output logic              rst_cmd,
  input  logic [MEM_AW-1:0] host_adr,
  output logic [7:0]        host_rdata
);
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADR, ST_WAIT, ST_RDDAT, ST_WRDAT, ST_SKIP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sck_s, r_ce_s;
  logic              r_sck_d, r_ce_d;
  logic [3:0]        r_sio_s1, r_sio_s2;
  logic [7:0]        r_cnt;
  logic              r_half, r_is_wr;
  logic [6:0]        r_cmd;
  logic [3:0]        r_wr_hi;
  logic [MEM_AW-1:0] r_adr;
  logic [7:0]        r_mem [2**MEM_AW];

  logic       w_sck_rise, w_sck_fall, w_ce_fall, w_ce_high, w_cnt_zero;
  logic       w_cmd_err, w_mem_we;
  logic [7:0] w_cmd_byte, w_rd_byte;

  assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign w_ce_high  = r_ce_s[1];
  assign w_ce_fall  = ~r_ce_s[1] & r_ce_d;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_cmd_byte = {r_cmd, r_sio_s2[0]};
  assign w_rd_byte  = r_mem[r_adr];
  assign w_mem_we   = (r_state == ST_WRDAT) && !w_ce_high && w_sck_rise && r_half;
  assign busy       = (r_state != ST_IDLE);

  // ce_n sync resets to "asserted" so a reset mid-frame cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_s  <= 2'b11;
      r_sck_d  <= 1'b1;
      r_ce_s   <= 2'b00;
      r_ce_d   <= 1'b0;
      r_sio_s1 <= '0;
      r_sio_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain shifts by one stage per clk.
      r_sck_s  <= {r_sck_s[0], sck};
      r_sck_d  <= r_sck_s[1];
      r_ce_s   <= {r_ce_s[0], ce_n};
      r_ce_d   <= r_ce_s[1];
      r_sio_s1 <= sio_in;
      r_sio_s2 <= r_sio_s1;
    end
  end

`ifdef QSPI_TGT_RSTCMD_EN
  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    w_state_nxt = r_state;
    w_cmd_err   = 1'b0;
    if (w_ce_high) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ce_fall) w_state_nxt = ST_CMD;
        ST_CMD: if (w_sck_rise && w_cnt_zero) begin
          case (w_cmd_byte)
            CMD_QREAD, CMD_QWRITE: w_state_nxt = ST_ADR;
`ifdef QSPI_TGT_RSTCMD_EN
            CMD_RSTEN, CMD_RST:    w_state_nxt = ST_SKIP;
`endif
            default: begin
              w_state_nxt = ST_SKIP;
              w_cmd_err   = 1'b1;
            end
          endcase
        end
        ST_ADR: if (w_sck_rise && w_cnt_zero)
          w_state_nxt = r_is_wr ? ST_WRDAT : ((WAIT_CYC == 0) ? ST_RDDAT : ST_WAIT);
        ST_WAIT: if (w_sck_rise && w_cnt_zero) w_state_nxt = ST_RDDAT;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_half  <= 1'b0;
      r_is_wr <= 1'b0;
      r_cmd   <= '0;
      r_wr_hi <= '0;
      r_adr   <= '0;
      sio_out <= '0;
      sio_oe  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      cmd_err <= w_cmd_err;
      if (w_ce_high) begin
        r_cnt   <= '0;
        r_half  <= 1'b0;
        sio_oe  <= 1'b0;
        sio_out <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_cnt <= 8'd7;
          ST_CMD: if (w_sck_rise) begin
            r_cmd <= w_cmd_byte[6:0];
            r_cnt <= w_cnt_zero ? 8'd5 : r_cnt - 8'd1;
            if (w_cnt_zero) r_is_wr <= (w_cmd_byte == CMD_QWRITE);
          end
          ST_ADR: if (w_sck_rise) begin
            r_adr <= MEM_AW'({r_adr, r_sio_s2});
            r_cnt <= w_cnt_zero ? 8'(WAIT_CYC - 1) : r_cnt - 8'd1;
          end
          ST_WAIT: if (w_sck_rise) r_cnt <= r_cnt - 8'd1;
          ST_RDDAT: if (w_sck_fall) begin
            sio_oe <= 1'b1;
            r_half <= ~r_half;
            if (r_half) begin
              sio_out <= w_rd_byte[3:0];
              r_adr   <= r_adr + MEM_AW'(1);
            end else begin
              sio_out <= w_rd_byte[7:4];
            end
          end
          ST_WRDAT: if (w_sck_rise) begin
            r_half <= ~r_half;
            if (r_half) r_adr   <= r_adr + MEM_AW'(1);
            else        r_wr_hi <= r_sio_s2;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would forbid block-RAM inference and its contents are defined by writes.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_adr] <= {r_wr_hi, r_sio_s2};
  end

  // Reading the pre-edge array value gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (rst) host_rdata <= '0;
    else     host_rdata <= r_mem[host_adr];
  end

`ifdef QSPI_TGT_RSTCMD_EN
  logic r_armed, w_arm_nxt, w_rst_hit;

  always_comb begin
    w_arm_nxt = r_armed;
    w_rst_hit = 1'b0;
    if (r_state == ST_CMD && !w_ce_high && w_sck_rise && w_cnt_zero) begin
      w_arm_nxt = (w_cmd_byte == CMD_RSTEN);
      w_rst_hit = (w_cmd_byte == CMD_RST) && r_armed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
      rst_cmd <= 1'b0;
    end else begin
      r_armed <= w_arm_nxt;
      rst_cmd <= w_rst_hit;
    end
  end
`else
  assign rst_cmd = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: acts as the QSPI initiator (SCK = clk/16) and checks RAM, pads and pulses.
// Build with QSPI_TGT_RSTCMD_EN defined to exercise the reset-command sequence.
module tb_qspi_target;
  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              rst, sck, ce_n;
  logic [3:0]        sio_in, sio_out;
  logic              sio_oe, busy, cmd_err, rst_cmd;
  logic [MEM_AW-1:0] host_adr;
  logic [7:0]        host_rdata;

  int n_vec = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int rst_pulses = 0;
  int oe_samples = 0;

  always #5 clk = ~clk;

  qspi_target #(.MEM_AW(MEM_AW), .WAIT_CYC(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ce_n       (ce_n),
    .sio_in     (sio_in),
    .sio_out    (sio_out),
    .sio_oe     (sio_oe),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .rst_cmd    (rst_cmd),
    .host_adr   (host_adr),
    .host_rdata (host_rdata)
  );

  // Single-clk pulses are seen at exactly one falling clk edge.
  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_pulses++;
    if (rst_cmd === 1'b1) rst_pulses++;
    if (sio_oe  === 1'b1) oe_samples++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q);
    sck    = 1'b0;
    sio_in = d;
    repeat (8) @(negedge clk);
    q   = sio_out;
    sck = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_begin();
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    ce_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, c[i]}, q);
  endtask

  task automatic send_adr(input logic [23:0] a);
    logic [3:0] q;
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], q);
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [31:0] data, input int nbytes);
    logic [3:0] q;
    frame_begin();
    send_cmd(8'h38);
    send_adr(a);
    for (int i = nbytes * 2 - 1; i >= 0; i--) sck_cycle(data[i*4 +: 4], q);
    frame_end();
  endtask

  // Returns nibbles packed MSB-first, OE samples seen before data, and sio_oe at the first data sample.
  task automatic read_nibbles(input logic [23:0] a, input int nnib,
                              output logic [31:0] got, output int oe_pre, output logic oe_first);
    logic [3:0] q;
    int         oe0;
    got = '0;
    oe0 = oe_samples;
    frame_begin();
    send_cmd(8'hEB);
    send_adr(a);
    for (int i = 0; i < 6; i++) sck_cycle(4'h0, q);
    oe_pre   = oe_samples - oe0;
    oe_first = 1'b0;
    for (int i = 0; i < nnib; i++) begin
      sck_cycle(4'h0, q);
      if (i == 0) oe_first = sio_oe;
      got = {got[27:0], q};
    end
    frame_end();
  endtask

  task automatic cmd_frame(input logic [7:0] c);
    logic [3:0] q;
    frame_begin();
    send_cmd(c);
    sck_cycle(4'h0, q);
    sck_cycle(4'h0, q);
    frame_end();
  endtask

  task automatic host_read(input logic [MEM_AW-1:0] a, output logic [7:0] d);
    host_adr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp_rd;
    logic [7:0]  d;
    logic [3:0]  q;
    logic        oe_first;
    int          oe_pre, e0, r0, o0;

    rst = 1'b1; sck = 1'b1; ce_n = 1'b1; sio_in = '0; host_adr = '0;
    repeat (4) @(negedge clk);
    check("rst_sio_out",    32'(sio_out),    32'h0);
    check("rst_sio_oe",     32'(sio_oe),     32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_cmd_err",    32'(cmd_err),    32'h0);
    check("rst_rst_cmd",    32'(rst_cmd),    32'h0);
    check("rst_host_rdata", 32'(host_rdata), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    e0 = err_pulses;

    // Write A5 3C at 0x10, observing busy mid-frame.
    frame_begin();
    send_cmd(8'h38);
    check("busy_in_frame", 32'(busy), 32'h1);
    send_adr(24'h000010);
    sck_cycle(4'hA, q); sck_cycle(4'h5, q); sck_cycle(4'h3, q); sck_cycle(4'hC, q);
    frame_end();
    host_read(10'h011, d); check("wr_ram_11", 32'(d), 32'h3C);
    host_read(10'h010, d); check("wr_ram_10", 32'(d), 32'hA5);

    // Quad read of 12 34 56 78 at 0x20.
    write_bytes(24'h000020, 32'h12345678, 4);
    read_nibbles(24'h000020, 8, got, oe_pre, oe_first);
    exp_rd = 32'h12345678;
    for (int i = 0; i < 8; i++)
      check($sformatf("rd_nibble_%0d", i), 32'(got[28 - 4*i +: 4]), 32'(exp_rd[28 - 4*i +: 4]));
    check("rd_oe_preamble", 32'(oe_pre), 32'h0);
    check("rd_oe_data",     32'(oe_first), 32'h1);
    check("rd_oe_after",    32'(sio_oe), 32'h0);

    // Address wrap at top of RAM.
    write_bytes(24'h0003FF, 32'h00001122, 2);
    host_read(10'h3FF, d); check("wrap_ram_3ff", 32'(d), 32'h11);
    host_read(10'h000, d); check("wrap_ram_000", 32'(d), 32'h22);

    // Aborted write after one nibble leaves the RAM untouched.
    write_bytes(24'h000040, 32'h0000005A, 1);
    frame_begin();
    send_cmd(8'h38);
    send_adr(24'h000040);
    sck_cycle(4'hF, q);
    ce_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy",  32'(busy),   32'h0);
    check("abort_sio_oe", 32'(sio_oe), 32'h0);
    repeat (4) @(negedge clk);
    host_read(10'h040, d); check("abort_ram_40", 32'(d), 32'h5A);
    check("no_err_valid_frames", 32'(err_pulses - e0), 32'h0);

    // Unknown command, then a good read.
    e0 = err_pulses;
    o0 = oe_samples;
    cmd_frame(8'h05);
    check("unk_err_pulses", 32'(err_pulses - e0), 32'h1);
    check("unk_oe_quiet",   32'(oe_samples - o0), 32'h0);
    read_nibbles(24'h000010, 2, got, oe_pre, oe_first);
    check("unk_next_read", got, 32'hA5);

`ifdef QSPI_TGT_RSTCMD_EN
    e0 = err_pulses; r0 = rst_pulses;
    cmd_frame(8'h66);
    cmd_frame(8'h99);
    check("rstcmd_pulse", 32'(rst_pulses - r0), 32'h1);
    check("rstcmd_no_err", 32'(err_pulses - e0), 32'h0);
    r0 = rst_pulses;
    cmd_frame(8'h66);
    cmd_frame(8'hEB);
    cmd_frame(8'h99);
    check("rstcmd_broken_seq", 32'(rst_pulses - r0), 32'h0);
`else
    e0 = err_pulses; r0 = rst_pulses;
    cmd_frame(8'h66);
    cmd_frame(8'h99);
    check("rstcmd_off_err",   32'(err_pulses - e0), 32'h2);
    check("rstcmd_off_pulse", 32'(rst_pulses - r0), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
